ram_mp_arb: RTL and testbench

// - Multi-client RAM slave with rq/ack handshake. NUM_CH client channels share one memory array through an internal round-robin arbiter.
// - Adds programmable ack latency, byte-enable writes and a clean abort of an unfinished request.
// - Sits behind the bus arbiter as the shared storage target; each client sees a dedicated rq/ack pair.

---
 rtl/ram_mp_pkg.sv | 23 ++
 rtl/ram_mp_arb_rr_arbiter.sv | 41 ++++
 rtl/ram_mp_arb.sv | 135 +++++++++++++
 tb/tb_ram_mp_arb.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_mp_pkg.sv
// Shared types and helpers for the multi-port RAM slave and its round-robin arbiter.
package ram_mp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        ACK    = 2'd3
    } state_t;

    localparam int MAX_ACK_DELAY = 15;

    // Ceiling log2, used to size channel indices and memory row indices.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_mp_arb_rr_arbiter.sv
// Combinational round-robin picker: first requesting channel at or after ptr, wrapping.
module rr_arbiter
    import ram_mp_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IW     = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IW-1:0]     ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [IW-1:0]     gnt_idx
);

    logic [2*NUM_CH-1:0] req_dbl;
    logic [NUM_CH-1:0]   rot;
    logic                found;
    int                  pos;

    // Rotating a doubled copy puts channel ptr at bit 0, so a plain priority scan works.
    assign req_dbl = {req, req} >> ptr;
    assign rot     = req_dbl[NUM_CH-1:0];

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                pos   = int'(ptr) + i;
                if (pos >= NUM_CH) begin
                    pos = pos - NUM_CH;
                end
                gnt_idx = IW'(pos);
                gnt     = NUM_CH'(1) << gnt_idx;
            end
        end
    end

endmodule

// File: rtl/ram_mp_arb.sv
// Shared RAM slave: NUM_CH rq/ack clients, round-robin service, programmable ack latency,
// byte-enable writes and silent abort when the granted client withdraws its request.
module ram_mp_arb
    import ram_mp_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int MEM_DEPTH  = 16,
    parameter int NUM_CH     = 4,
    parameter int ACK_DELAY  = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CH-1:0]              rq,
    input  logic [NUM_CH-1:0]              wr_ni,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   address,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   dataW,
    input  logic [NUM_CH*DATA_WIDTH/8-1:0] be,
    output logic [NUM_CH-1:0]              ack,
    output logic [DATA_WIDTH-1:0]          dataR,
    output state_t                         fsm_state
);

    localparam int IW = clog2(NUM_CH);
    localparam int NB = DATA_WIDTH / 8;
    localparam int MW = (MEM_DEPTH > 1) ? clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [3:0]          LAST_CNT = (ACK_DELAY > 0) ? 4'(ACK_DELAY - 1) : 4'd0;
    localparam logic [IW-1:0]       LAST_CH  = IW'(NUM_CH - 1);

    // Handshake: a client raises rq with wr_ni/address/dataW/be stable and holds all of them
    // until its ack pulse; it lowers rq in the following cycle. Dropping rq before ack aborts.
    state_t            state, state_nx;
    logic [3:0]        cnt;
    logic [IW-1:0]     grant, rr_ptr;
    logic [NUM_CH-1:0] arb_gnt;
    logic [IW-1:0]     arb_idx;
    logic              any_req;
    logic              go_access;

    logic                  g_rq, g_rd, in_range;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [DATA_WIDTH-1:0] g_wdata;
    logic [NB-1:0]         g_be;
    logic [MW-1:0]         mem_idx;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    rr_arbiter #(.NUM_CH(NUM_CH), .IW(IW)) u_arb (
        .req     (rq),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign any_req  = |arb_gnt;
    assign g_rq     = rq[grant];
    assign g_rd     = wr_ni[grant];
    assign g_addr   = address[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
    assign g_wdata  = dataW[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    assign g_be     = be[int'(grant)*NB +: NB];
    assign in_range = {1'b0, g_addr} < DEPTH_L;
    assign mem_idx  = g_addr[MW-1:0];

    always_comb begin
        state_nx  = state;
        go_access = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    if (ACK_DELAY > 0) state_nx = WAIT;
                    else               state_nx = ACCESS;
                end
            end
            WAIT: begin
                if (!g_rq)                 state_nx = IDLE;
                else if (cnt == LAST_CNT)  state_nx = ACCESS;
            end
            ACCESS: begin
                if (!g_rq) begin
                    state_nx = IDLE;
                end else begin
                    state_nx  = ACK;
                    go_access = 1'b1;
                end
            end
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            grant  <= '0;
            rr_ptr <= '0;
            dataR  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                grant  <= arb_idx;
                cnt    <= 4'd0;
                rr_ptr <= (arb_idx == LAST_CH) ? '0 : arb_idx + 1'b1;
            end
            if (state == WAIT) begin
                cnt <= cnt + 4'd1;
            end
            if (go_access && g_rd) begin
                dataR <= in_range ? mem[mem_idx] : '0;
            end
        end
    end

    // Storage is deliberately not reset; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (go_access && !g_rd && in_range) begin
            for (int k = 0; k < NB; k++) begin
                if (g_be[k]) begin
                    mem[mem_idx][k*8 +: 8] <= g_wdata[k*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        ack = '0;
        if (state == ACK) begin
            ack[grant] = 1'b1;
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_ram_mp_arb.sv
// Bench for ram_mp_arb: directed latency/byte-enable/arbitration/abort/reset cases plus a
// randomized multi-client run scored against a transaction-level model.
module tb_ram_mp_arb;
    import ram_mp_pkg::*;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int N  = 4;
    localparam int D  = 2;
    localparam int NB = DW / 8;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // main DUT: default parameters
    logic [N-1:0]     rq, wr_ni, ack;
    logic [N*AW-1:0]  address;
    logic [N*DW-1:0]  dataW;
    logic [N*NB-1:0]  be;
    logic [DW-1:0]    dataR;
    state_t           fsm_state;

    // second DUT: zero ack delay, half-populated memory
    logic [1:0]       rq_b, wr_b, ack_b;
    logic [2*AW-1:0]  addr_b;
    logic [2*DW-1:0]  dw_b;
    logic [2*NB-1:0]  be_b;
    logic [DW-1:0]    dr_b;
    state_t           st_b;

    ram_mp_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(16), .NUM_CH(N), .ACK_DELAY(D)) u_dut (
        .clk(clk), .reset(reset), .rq(rq), .wr_ni(wr_ni), .address(address), .dataW(dataW),
        .be(be), .ack(ack), .dataR(dataR), .fsm_state(fsm_state)
    );

    ram_mp_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(8), .NUM_CH(2), .ACK_DELAY(0)) u_dut_b (
        .clk(clk), .reset(reset), .rq(rq_b), .wr_ni(wr_b), .address(addr_b), .dataW(dw_b),
        .be(be_b), .ack(ack_b), .dataR(dr_b), .fsm_state(st_b)
    );

    // scoreboard
    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] model_mem [16];
    logic [DW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    int            exp_ch_q[$];
    bit            exp_rd_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no ack within bound (t=%0t)", tag, $time);
    endtask

    function automatic int first_from(input logic [N-1:0] v, input int p);
        for (int off = 0; off < N; off++) begin
            if (v[(p + off) % N]) return (p + off) % N;
        end
        return -1;
    endfunction

    // driver tasks
    task automatic set_ch(input int c, input bit rd, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [NB-1:0] b);
        wr_ni[c]             = rd;
        address[c*AW +: AW]  = a;
        dataW[c*DW +: DW]    = d;
        be[c*NB +: NB]       = b;
    endtask

    task automatic txn(input int c, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [NB-1:0] b, output int lat, output logic [DW-1:0] rdata);
        @(posedge clk); #1;
        set_ch(c, rd, a, d, b);
        rq[c] = 1'b1;
        lat   = -1;
        rdata = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ack[c]) begin
                lat   = n;
                rdata = dataR;
                break;
            end
        end
        if (lat < 0) timeout_fail("txn");
        @(posedge clk); #1;
        rq[c] = 1'b0;
    endtask

    task automatic txn_b(input int c, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int lat, output logic [DW-1:0] rdata);
        @(posedge clk); #1;
        wr_b[c]            = rd;
        addr_b[c*AW +: AW] = a;
        dw_b[c*DW +: DW]   = d;
        be_b[c*NB +: NB]   = '1;
        rq_b[c]            = 1'b1;
        lat   = -1;
        rdata = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ack_b[c]) begin
                lat   = n;
                rdata = dr_b;
                break;
            end
        end
        if (lat < 0) timeout_fail("txn_b");
        @(posedge clk); #1;
        rq_b[c] = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            lat, ch, gap_r, t_ack3, free, mptr, drained;
        logic [DW-1:0] rd, wd;
        logic [AW-1:0] a;
        logic [NB-1:0] b;
        int            ev_t[5], ev_c[5], n_ev;
        bit            drop[N], saw_ack2;
        int            nz_ack;
        bit            active[N], acked[N];
        int            gap[N], age[N];
        int            exp_t[5], exp_c[5];

        exp_t = '{4, 9, 14, 19, 24};
        exp_c = '{0, 1, 2, 3, 0};
        reset = 1'b0;
        rq = '0; wr_ni = '0; address = '0; dataW = '0; be = '0;
        rq_b = '0; wr_b = '0; addr_b = '0; dw_b = '0; be_b = '0;
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_dataR", dataR, 0);
        check("rst_state", fsm_state, IDLE);
        check("rst_ack_b", ack_b, 0);
        check("rst_dataR_b", dr_b, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // basic write/read latency
        txn(0, 1'b0, 4'd3, 16'h12A5, 2'b11, lat, rd);
        check("wr_lat", lat, 4);
        txn(0, 1'b1, 4'd3, 16'h0000, 2'b00, lat, rd);
        check("rd_lat", lat, 4);
        check("rd_data", rd, 16'h12A5);

        // byte enables
        txn(1, 1'b0, 4'd5, 16'h1234, 2'b11, lat, rd);
        txn(1, 1'b0, 4'd5, 16'hABCD, 2'b10, lat, rd);
        txn(1, 1'b1, 4'd5, 16'h0000, 2'b00, lat, rd);
        check("be_hi_data", rd, 16'hAB34);
        txn(2, 1'b0, 4'd5, 16'hFFFF, 2'b00, lat, rd);
        check("be0_lat", lat, 4);
        txn(2, 1'b1, 4'd5, 16'h0000, 2'b00, lat, rd);
        check("be0_data", rd, 16'hAB34);

        // four simultaneous requests after reset, ch0 re-requests
        pulse_reset();
        @(posedge clk); #1;
        for (int c = 0; c < N; c++) begin
            set_ch(c, 1'b1, 4'd3, 16'h0, 2'b00);
            drop[c] = 1'b0;
        end
        rq   = '1;
        n_ev = 0;
        for (int t = 0; t < 30; t++) begin
            if (t > 0) begin
                @(posedge clk); #1;
            end
            for (int c = 0; c < N; c++) begin
                if (drop[c]) begin
                    rq[c]   = 1'b0;
                    drop[c] = 1'b0;
                end
            end
            if (t == 6) rq[0] = 1'b1;
            @(negedge clk);
            if (ack != '0) begin
                check("rr_onehot", $countones(ack), 1);
                if (n_ev < 5) begin
                    ev_t[n_ev] = t;
                    ev_c[n_ev] = first_from(ack, 0);
                end
                n_ev++;
                for (int c = 0; c < N; c++) if (ack[c]) drop[c] = 1'b1;
            end
        end
        check("rr_count", n_ev, 5);
        for (int i = 0; i < 5; i++) begin
            if (i < n_ev) begin
                check("rr_ch", ev_c[i], exp_c[i]);
                check("rr_cycle", ev_t[i], exp_t[i]);
            end
        end

        // ch2 write aborted in its second WAIT cycle; pending ch3 read served next
        @(posedge clk); #1;
        set_ch(2, 1'b0, 4'd3, 16'h5555, 2'b11);
        rq[2]    = 1'b1;
        saw_ack2 = 1'b0;
        t_ack3   = -1;
        rd       = '0;
        for (int t = 0; t < 14; t++) begin
            if (t > 0) begin
                @(posedge clk); #1;
            end
            if (t == 1) begin
                set_ch(3, 1'b1, 4'd3, 16'h0, 2'b00);
                rq[3] = 1'b1;
            end
            if (t == 2) rq[2] = 1'b0;
            if (t_ack3 >= 0 && t == t_ack3 + 1) rq[3] = 1'b0;
            @(negedge clk);
            if (t == 3) check("abort_idle", fsm_state, IDLE);
            if (ack[2]) saw_ack2 = 1'b1;
            if (ack[3]) begin
                t_ack3 = t;
                rd     = dataR;
            end
        end
        check("abort_no_ack", saw_ack2, 0);
        check("abort_next_cycle", t_ack3, 7);
        check("abort_mem_kept", rd, 16'h12A5);

        // reset during WAIT of a ch1 write
        txn(0, 1'b0, 4'd7, 16'h0F0F, 2'b11, lat, rd);
        @(posedge clk); #1;
        set_ch(1, 1'b0, 4'd7, 16'hDEAD, 2'b11);
        rq[1] = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_wait", fsm_state, WAIT);
        reset = 1'b1;
        rq[1] = 1'b0;
        nz_ack = 0;
        @(negedge clk);
        check("rst_mid_dataR", dataR, 0);
        check("rst_mid_state", fsm_state, IDLE);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack != '0) nz_ack++;
        end
        check("rst_mid_no_ack", nz_ack, 0);
        txn(0, 1'b1, 4'd7, 16'h0, 2'b00, lat, rd);
        check("rst_mid_mem", rd, 16'h0F0F);
        txn(1, 1'b1, 4'd7, 16'h0, 2'b00, lat, rd);
        check("rst_mid_ch1_lat", lat, 4);

        // zero delay, MEM_DEPTH=8 instance
        txn_b(0, 1'b0, 4'd2, 16'h7777, lat, rd);
        check("d0_wr_lat", lat, 2);
        txn_b(1, 1'b1, 4'd2, 16'h0, lat, rd);
        check("d0_rd_lat", lat, 2);
        check("d0_rd_data", rd, 16'h7777);
        txn_b(0, 1'b1, 4'd15, 16'h0, lat, rd);
        check("d0_oor_lat", lat, 2);
        check("d0_oor_data", rd, 16'h0000);
        txn_b(0, 1'b0, 4'd4, 16'h4444, lat, rd);
        txn_b(1, 1'b0, 4'd12, 16'hBEEF, lat, rd);
        check("d0_oor_wr_lat", lat, 2);
        txn_b(1, 1'b1, 4'd4, 16'h0, lat, rd);
        check("d0_oor_wr_dropped", rd, 16'h4444);
        check("d0_state_idle", st_b, IDLE);

        // randomized multi-client run against a transaction-level model
        for (int i = 0; i < 16; i++) begin
            wd = DW'($urandom);
            txn(i % N, 1'b0, AW'(i), wd, 2'b11, lat, rd);
            model_mem[i] = wd;
        end
        pulse_reset();
        free = 0;
        mptr = 0;
        for (int c = 0; c < N; c++) begin
            active[c] = 1'b0; acked[c] = 1'b0; gap[c] = $urandom_range(0, 3); age[c] = 0;
        end
        drained = 0;
        for (int t = 0; t < 900; t++) begin
            @(posedge clk); #1;
            for (int c = 0; c < N; c++) begin
                if (active[c]) begin
                    age[c]++;
                    if (acked[c]) begin
                        rq[c] = 1'b0; active[c] = 1'b0; acked[c] = 1'b0;
                        gap_r = $urandom_range(0, 4);
                        gap[c] = gap_r;
                    end else if (age[c] > 60) begin
                        timeout_fail("rand_client");
                        rq[c] = 1'b0; active[c] = 1'b0;
                    end
                end else if (gap[c] > 0) begin
                    gap[c]--;
                end else if (t < 600) begin
                    a = AW'($urandom_range(0, 15));
                    b = NB'($urandom_range(0, 3));
                    set_ch(c, 1'($urandom_range(0, 1)), a, DW'($urandom), b);
                    rq[c] = 1'b1; active[c] = 1'b1; age[c] = 0;
                end
            end
            @(negedge clk);
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == t) begin
                ch = exp_ch_q.pop_front();
                void'(exp_cyc_q.pop_front());
                wd = exp_q.pop_front();
                check("rand_ack", ack, 32'(1) << ch);
                if (exp_rd_q.pop_front()) check("rand_rdata", dataR, wd);
            end else begin
                check("rand_ack_quiet", ack, 0);
            end
            for (int c = 0; c < N; c++) if (ack[c] && active[c]) acked[c] = 1'b1;
            if (t >= free && rq != '0) begin
                ch = first_from(rq, mptr);
                a  = address[ch*AW +: AW];
                if (wr_ni[ch]) begin
                    exp_q.push_back(model_mem[a]);
                end else begin
                    wd = dataW[ch*DW +: DW];
                    b  = be[ch*NB +: NB];
                    for (int k = 0; k < NB; k++) if (b[k]) model_mem[a][k*8 +: 8] = wd[k*8 +: 8];
                    exp_q.push_back('0);
                end
                exp_rd_q.push_back(wr_ni[ch]);
                exp_ch_q.push_back(ch);
                exp_cyc_q.push_back(t + D + 2);
                free = t + D + 3;
                mptr = (ch + 1) % N;
            end
            if (t >= 600 && rq == '0 && exp_cyc_q.size() == 0) begin
                drained = 1;
                break;
            end
        end
        check("rand_drained", drained, 1);
        check("rand_queue_empty", exp_cyc_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
